// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// con codes, FSM state encoding and default width.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] CON_MULU = 4'b1100;
  localparam logic [3:0] CON_DIVU = 4'b1101;
  localparam logic [3:0] CON_MUL  = 4'b1110;
  localparam logic [3:0] CON_DIV  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Ports: isDiv (op kind), accIn/accOut (2*WIDTH accumulator),
// opnd (multiplicand or divisor magnitude).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               isDiv,
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] accOut
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, accIn[2*WIDTH-1:WIDTH]};
    if (accIn[0]) begin
      sum = sum + {1'b0, opnd};
    end
    // partial remainder after shifting in the next dividend bit
    rem  = accIn[2*WIDTH-1:WIDTH-1];
    diff = rem - {1'b0, opnd};
    if (isDiv) begin
      if (diff[WIDTH]) begin
        accOut = {rem[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
      end else begin
        accOut = {diff[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1};
      end
    end else begin
      accOut = {sum, accIn[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage multiply/divide unit owning the HI/LO pair.
// Ports: clk, rst_n (sync low), start/con/a/b issue an op,
// hiloR/hiloS read HI/LO, flush squashes; hiloOut, busy,
// stall, done, dbz report status.
// Build option: HILO_FAST_MUL_EN gives single-cycle multiply.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       con,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hiloR,
  input  logic             hiloS,
  input  logic             flush,
  output logic [WIDTH-1:0] hiloOut,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

`ifdef HILO_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  muldiv_state_t state;
  muldiv_state_t stateNext;

  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] stepOut;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic               isDivQ;
  logic               resNegQ;
  logic               remNegQ;
  logic               dbzQ;

  logic               validCon;
  logic               isDivCon;
  logic               signedCon;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic               resNeg;
  logic               remNeg;
  logic               bZero;
  logic               accept;
  logic               skipCalc;

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  always_comb begin
    validCon  = 1'b0;
    isDivCon  = 1'b0;
    signedCon = 1'b0;
    unique case (1'b1)
      (con == CON_MULU): begin
        validCon = 1'b1;
      end
      (con == CON_DIVU): begin
        validCon = 1'b1;
        isDivCon = 1'b1;
      end
      (con == CON_MUL): begin
        validCon  = 1'b1;
        signedCon = 1'b1;
      end
      (con == CON_DIV): begin
        validCon  = 1'b1;
        isDivCon  = 1'b1;
        signedCon = 1'b1;
      end
      default: begin
        validCon = 1'b0;
      end
    endcase
  end

  always_comb begin
    magA   = (signedCon && a[WIDTH-1]) ? -a : a;
    magB   = (signedCon && b[WIDTH-1]) ? -b : b;
    resNeg = signedCon & (a[WIDTH-1] ^ b[WIDTH-1]);
    remNeg = signedCon & a[WIDTH-1];
    bZero  = isDivCon && (b == '0);
    // divide by zero and fast multiply finish without iterating
    skipCalc = bZero | (FAST_MUL & ~isDivCon);
  end

  assign accept = start & validCon & ~flush & (state == IDLE);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) uStep (
    .isDiv  (isDivQ),
    .accIn  (acc),
    .opnd   (opnd),
    .accOut (stepOut)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    done      = 1'b0;
    dbz       = 1'b0;
    if (flush) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            stateNext = skipCalc ? FIX : CALC;
          end
        end
        CALC: begin
          if (cnt == CW'(WIDTH - 1)) begin
            stateNext = FIX;
          end
        end
        FIX: begin
          stateNext = IDLE;
          done      = 1'b1;
          dbz       = dbzQ;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    prodFix = resNegQ ? -acc : acc;
    quoFix  = resNegQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix  = remNegQ ? -acc[2*WIDTH-1:WIDTH]
                      : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      isDivQ  <= 1'b0;
      resNegQ <= 1'b0;
      remNegQ <= 1'b0;
      dbzQ    <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= '0;
        isDivQ  <= isDivCon;
        resNegQ <= resNeg;
        remNegQ <= remNeg;
        dbzQ    <= bZero;
        if (bZero) begin
          acc  <= {a, {WIDTH{1'b1}}};
          opnd <= '0;
        end else if (isDivCon) begin
          acc  <= {{WIDTH{1'b0}}, magA};
          opnd <= magB;
        end else begin
`ifdef HILO_FAST_MUL_EN
          acc  <= {{WIDTH{1'b0}}, magA}
                * {{WIDTH{1'b0}}, magB};
`else
          acc  <= {{WIDTH{1'b0}}, magB};
`endif
          opnd <= magA;
        end
      end else if (state == CALC && !flush) begin
        acc <= stepOut;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !flush) begin
        if (dbzQ) begin
          hi <= acc[2*WIDTH-1:WIDTH];
          lo <= acc[WIDTH-1:0];
        end else if (isDivQ) begin
          hi <= remFix;
          lo <= quoFix;
        end else begin
          hi <= prodFix[2*WIDTH-1:WIDTH];
          lo <= prodFix[WIDTH-1:0];
        end
      end
    end
  end

  assign hiloOut = hiloS ? lo : hi;
  assign busy    = (state != IDLE);
  assign stall   = busy & (hiloR | start);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: cycle model of
// HI/LO timing plus directed vectors with literal results.
module tb_hilo_muldiv_unit;

  localparam int W = 32;
`ifdef HILO_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   con;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hiloR;
  logic         hiloS;
  logic         flush;
  logic [W-1:0] hiloOut;
  logic         busy;
  logic         stall;
  logic         done;
  logic         dbz;

  int checks = 0;
  int failures = 0;
  int doneCnt = 0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .con     (con),
    .a       (a),
    .b       (b),
    .hiloR   (hiloR),
    .hiloS   (hiloS),
    .flush   (flush),
    .hiloOut (hiloOut),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .dbz     (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // architectural result of one op, from plain arithmetic
  task automatic calc(input logic [3:0] c, input logic [31:0] x,
                      input logic [31:0] y, output logic [31:0] h,
                      output logic [31:0] l, output bit dz);
    longint sx, sy, p, q, r;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    h  = '0;
    l  = '0;
    if (c[0] && y == 0) begin
      dz = 1'b1;
      h  = x;
      l  = '1;
    end else if (c == 4'b1100) begin
      up = {32'b0, x} * {32'b0, y};
      h  = up[63:32];
      l  = up[31:0];
    end else if (c == 4'b1110) begin
      p = sx * sy;
      h = p[63:32];
      l = p[31:0];
    end else if (c == 4'b1101) begin
      l = x / y;
      h = x % y;
    end else begin
      q = sx / sy;
      r = sx % sy;
      l = q[31:0];
      h = r[31:0];
    end
  endtask

  logic [31:0] mHi, mLo, pHi, pLo;
  bit          pDz;
  bit          mValid = 1'b0;
  int          mLeft = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mHi = '0;
      mLo = '0;
      mLeft = 0;
      mValid = 1'b1;
    end else if (flush) begin
      mLeft = 0;
    end else if (mLeft > 0) begin
      if (mLeft == 1) begin
        mHi = pHi;
        mLo = pLo;
      end
      mLeft--;
    end else if (start && con[3:2] == 2'b11) begin
      calc(con, a, b, pHi, pLo, pDz);
      if (pDz) mLeft = 1;
      else if (con[0]) mLeft = W + 1;
      else mLeft = MUL_LAT;
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      automatic bit eBusy = (mLeft > 0);
      automatic bit eDone = (mLeft == 1) && !flush;
      chk("busy", busy, eBusy);
      chk("stall", stall, eBusy && (hiloR || start));
      chk("done", done, eDone);
      chk("dbz", dbz, eDone && pDz);
      chk("hiloOut", hiloOut, hiloS ? mLo : mHi);
      if (done) doneCnt++;
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] x,
                       input logic [31:0] y);
    @(posedge clk);
    #1 start = 1'b1;
    con = c;
    a = x;
    b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int maxc, output int n,
                          output int nb, output bit dz);
    n = 0;
    nb = 0;
    dz = 1'b0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        n = i;
        dz = dbz;
        break;
      end
    end
    if (n == 0) $display("FAIL done_timeout actual=none required=pulse");
    @(posedge clk);
    #1;
  endtask

  task automatic readHL(input string nm, input logic [31:0] eh,
                        input logic [31:0] el);
    hiloS = 1'b0;
    @(negedge clk);
    chk({nm, "_hi"}, hiloOut, eh);
    @(posedge clk);
    #1 hiloS = 1'b1;
    @(negedge clk);
    chk({nm, "_lo"}, hiloOut, el);
    @(posedge clk);
    #1 hiloS = 1'b0;
  endtask

  int n, nb, k;
  bit dz;
  int dc;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    con = '0;
    a = '0;
    b = '0;
    hiloR = 1'b0;
    hiloS = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #1;
    readHL("reset", 32'h0, 32'h0);

    issue(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(60, n, nb, dz);
    chk("multu_done_edge", n, MUL_LAT);
    chk("multu_busy_cycles", nb, MUL_LAT);
    readHL("multu", 32'hFFFFFFFE, 32'h00000001);

    issue(4'b1110, -32'sd3, 32'd7);
    waitDone(60, n, nb, dz);
    readHL("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

    issue(4'b1111, -32'sd7, 32'd2);
    waitDone(60, n, nb, dz);
    chk("div_done_edge", n, W + 1);
    readHL("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(4'b1101, 32'd100, 32'd0);
    waitDone(60, n, nb, dz);
    chk("dbz_done_edge", n, 1);
    chk("dbz_flag", dz, 1);
    readHL("divu0", 32'h00000064, 32'hFFFFFFFF);

    issue(4'b1111, 32'h80000000, 32'hFFFFFFFF);
    waitDone(60, n, nb, dz);
    chk("ovf_no_dbz", dz, 0);
    readHL("ovf", 32'h0, 32'h80000000);

    issue(4'b1101, 32'd9, 32'd4);
    repeat (4) @(posedge clk);
    #1 hiloR = 1'b1;
    hiloS = 1'b0;
    k = 0;
    for (int i = 5; i <= 60; i++) begin
      @(negedge clk);
      if (!stall) begin
        k = i;
        break;
      end
    end
    chk("mfhi_release_cycle", k, W + 2);
    chk("mfhi_value", hiloOut, 32'h1);
    @(posedge clk);
    #1 hiloS = 1'b1;
    @(negedge clk);
    chk("mflo_value", hiloOut, 32'h2);
    @(posedge clk);
    #1 hiloR = 1'b0;
    hiloS = 1'b0;

    issue(4'b1101, 32'd30, 32'd6);
    @(posedge clk);
    #1 start = 1'b1;
    con = 4'b1100;
    a = 32'd5;
    b = 32'd5;
    @(negedge clk);
    chk("busy_start_stall", stall, 1);
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(60, n, nb, dz);
    readHL("divu_busy", 32'h0, 32'h5);

    @(posedge clk);
    #1 start = 1'b1;
    con = 4'b0010;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("bad_con_ignored", busy, 0);
    @(posedge clk);
    #1 start = 1'b1;
    con = 4'b1100;
    flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_beats_start", busy, 0);

    issue(4'b1101, 32'h451, 32'h20);
    waitDone(60, n, nb, dz);
    readHL("setup1", 32'h11, 32'h22);
    dc = doneCnt;
    issue(4'b1111, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_no_done", doneCnt, dc);
    readHL("flush", 32'h11, 32'h22);

    issue(4'b1101, 32'h451, 32'h20);
    waitDone(60, n, nb, dz);
    readHL("setup2", 32'h11, 32'h22);
    issue(4'b1111, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    readHL("rst", 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
